// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential add/subtract unit.
// Holds the FSM state encoding, the op_sub encoding and the chunk-count helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } addsub_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of compute cycles needed to sweep all chunks of an operand.
    function automatic int unsigned num_chunks(input int unsigned width,
                                               input int unsigned chunk_w);
        return width / chunk_w;
    endfunction

endpackage

// File: rtl/addsub_seq_unit_if.sv
// Operand/result handshake bundle for addsub_seq_unit.
// master: operand issuer + result consumer; slave: the arithmetic unit.
//   in_valid/in_ready, op_sub, op_signed, a, b   : operand request channel
//   out_valid/out_ready, result + flags          : result channel
interface addsub_seq_unit_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic             op_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, op_sub, op_signed, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, op_sub, op_signed, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice with carry-in and carry-out.
//   i_a, i_b  : addends
//   i_cin     : carry-in
//   o_sum_c   : W-bit sum
//   o_cout_c  : carry-out
module addsub_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum_c,
    output logic         o_cout_c
);
    assign {o_cout_c, o_sum_c} = (W+1)'(i_a) + (W+1)'(i_b) + (W+1)'(i_cin);
endmodule

// File: rtl/addsub_seq_unit.sv
// Sequential add/subtract unit: one CHUNK_W-bit slice per cycle, carry held
// in a register between slices. Reports carry/overflow/zero/negative.
// Optional result saturation on overflow when ADDSUB_SAT_EN is defined.
//   clk    : clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : addsub_seq_unit_if.slave (operand and result handshakes)
module addsub_seq_unit
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    addsub_seq_unit_if.slave  bus
);
    localparam int unsigned NUM_CHUNKS = num_chunks(WIDTH, CHUNK_W);
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned MSB        = WIDTH - 1;

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_BUSY = 2'(ST_BUSY);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    if ((WIDTH % CHUNK_W) != 0) begin : g_bad_cfg
        $error("addsub_seq_unit: WIDTH must be a multiple of CHUNK_W");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b_eff;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op_sub;
    logic               r_op_signed;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;
    logic               r_negative;
    logic               r_out_valid;

    logic [CHUNK_W-1:0] w_a_chunk;
    logic [CHUNK_W-1:0] w_b_chunk;
    logic [CHUNK_W-1:0] w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;
    logic [WIDTH-1:0]   w_res_final;
    logic               w_ovf_raw;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(NUM_CHUNKS - 1));

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next_state = S_BUSY;
            S_BUSY:  if (w_last)        w_next_state = S_DONE;
            S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    // Pick the operand slice addressed by the chunk counter
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_chunk = r_a[k*CHUNK_W +: CHUNK_W];
                w_b_chunk = r_b_eff[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    addsub_chunk #(.W(CHUNK_W)) u_chunk (
        .i_a      (w_a_chunk),
        .i_b      (w_b_chunk),
        .i_cin    (r_carry),
        .o_sum_c  (w_sum),
        .o_cout_c (w_cout)
    );

    // Merge the fresh slice into the partial result
    always_comb begin
        w_res_next = r_result;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (r_cnt == CNT_W'(k)) w_res_next[k*CHUNK_W +: CHUNK_W] = w_sum;
        end
    end

    // Overflow per mode; optional clamp of the completed result
    always_comb begin
        if (r_op_signed)
            w_ovf_raw = (r_a[MSB] == r_b_eff[MSB]) && (w_res_next[MSB] != r_a[MSB]);
        else
            w_ovf_raw = (r_op_sub == OP_SUB) ? ~w_cout : w_cout;
        w_res_final = w_res_next;
`ifdef ADDSUB_SAT_EN
        if (w_ovf_raw) begin
            if (r_op_signed) begin
                // Both operands share a sign; that sign tells which rail was crossed.
                w_res_final      = r_a[MSB] ? '0 : '1;
                w_res_final[MSB] = r_a[MSB];
            end else begin
                w_res_final = (r_op_sub == OP_SUB) ? '0 : '1;
            end
        end
`endif
    end

    // Operand capture, per-chunk accumulation and flag registration
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_a         <= '0;
            r_b_eff     <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_op_sub    <= 1'b0;
            r_op_signed <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a         <= bus.a;
                        r_b_eff     <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
                        r_carry     <= bus.op_sub;
                        r_op_sub    <= bus.op_sub;
                        r_op_signed <= bus.op_signed;
                        r_cnt       <= '0;
                    end
                end
                S_BUSY: begin
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result    <= w_res_final;
                        r_carry_out <= w_cout;
                        r_overflow  <= w_ovf_raw;
                        r_zero      <= (w_res_final == '0);
                        r_negative  <= r_op_signed & w_res_final[MSB];
                        r_out_valid <= 1'b1;
                    end else begin
                        r_result <= w_res_next;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry     = r_carry_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Directed bench for addsub_seq_unit: main 16/4 instance plus three
// parameter-sweep instances (16/16, 16/1, 32/8) sharing clock and reset.
module tb_addsub_seq_unit;
    logic clk = 1'b0;
    logic n_rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    addsub_seq_unit_if #(.WIDTH(16)) bus ();
    addsub_seq_unit_if #(.WIDTH(16)) bus_c16 ();
    addsub_seq_unit_if #(.WIDTH(16)) bus_c1 ();
    addsub_seq_unit_if #(.WIDTH(32)) bus_w32 ();

    addsub_seq_unit #(.WIDTH(16), .CHUNK_W(4))  u_dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    addsub_seq_unit #(.WIDTH(16), .CHUNK_W(16)) u_c16 (.clk(clk), .n_rst(n_rst), .bus(bus_c16));
    addsub_seq_unit #(.WIDTH(16), .CHUNK_W(1))  u_c1  (.clk(clk), .n_rst(n_rst), .bus(bus_c1));
    addsub_seq_unit #(.WIDTH(32), .CHUNK_W(8))  u_w32 (.clk(clk), .n_rst(n_rst), .bus(bus_w32));

`ifdef ADDSUB_SAT_EN
    localparam logic [15:0] EXP_SUB_UF  = 16'h0000;
    localparam logic        EXP_SUB_UFZ = 1'b1;
    localparam logic [15:0] EXP_SADD_OV = 16'h7FFF;
    localparam logic        EXP_SADD_N  = 1'b0;
    localparam logic [15:0] EXP_UADD_OV = 16'hFFFF;
    localparam logic        EXP_UADD_Z  = 1'b0;
    localparam logic [31:0] EXP_W32     = 32'h8000_0000;
`else
    localparam logic [15:0] EXP_SUB_UF  = 16'hFFFF;
    localparam logic        EXP_SUB_UFZ = 1'b0;
    localparam logic [15:0] EXP_SADD_OV = 16'h8000;
    localparam logic        EXP_SADD_N  = 1'b1;
    localparam logic [15:0] EXP_UADD_OV = 16'h0000;
    localparam logic        EXP_UADD_Z  = 1'b1;
    localparam logic [31:0] EXP_W32     = 32'h7FFF_FFFF;
`endif

    // Issue one operation on the main unit; lat = edges from accept to out_valid.
    task automatic issue16(input logic sub, input logic sgn,
                           input logic [15:0] a, input logic [15:0] b, output int lat);
        for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op_sub = sub; bus.op_signed = sgn; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic drain16();
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if ({bus.result, bus.carry, bus.overflow, bus.zero, bus.negative} !== 20'h0) begin
            n_err++; $display("FAIL reset_result_flags: got %h %b%b%b%b want 0", bus.result, bus.carry, bus.overflow, bus.zero, bus.negative); end
        @(negedge clk); n_rst = 1'b1;
    endtask

    task automatic test_unsigned_sub();
        int lat;
        issue16(1'b1, 1'b0, 16'h1234, 16'h0234, lat);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL usub_latency: got %0d want 4", lat); end
        n_vec++; if (bus.result !== 16'h1000) begin n_err++; $display("FAIL usub_result: got %h want 1000", bus.result); end
        n_vec++; if ({bus.carry, bus.overflow, bus.zero, bus.negative} !== 4'b1000) begin
            n_err++; $display("FAIL usub_flags: got %b%b%b%b want 1000", bus.carry, bus.overflow, bus.zero, bus.negative); end
        drain16();
        n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL usub_release: got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready); end
        issue16(1'b1, 1'b0, 16'h0001, 16'h0002, lat);
        n_vec++; if (bus.result !== EXP_SUB_UF) begin n_err++; $display("FAIL usub_borrow_result: got %h want %h", bus.result, EXP_SUB_UF); end
        n_vec++; if ({bus.carry, bus.overflow, bus.zero, bus.negative} !== {1'b0, 1'b1, EXP_SUB_UFZ, 1'b0}) begin
            n_err++; $display("FAIL usub_borrow_flags: got %b%b%b%b want 01%b0", bus.carry, bus.overflow, bus.zero, bus.negative, EXP_SUB_UFZ); end
        drain16();
    endtask

    task automatic test_signed_add();
        int lat;
        issue16(1'b0, 1'b1, 16'h7FFF, 16'h0001, lat);
        n_vec++; if (bus.result !== EXP_SADD_OV) begin n_err++; $display("FAIL sadd_ovf_result: got %h want %h", bus.result, EXP_SADD_OV); end
        n_vec++; if ({bus.carry, bus.overflow, bus.zero, bus.negative} !== {1'b0, 1'b1, 1'b0, EXP_SADD_N}) begin
            n_err++; $display("FAIL sadd_ovf_flags: got %b%b%b%b want 010%b", bus.carry, bus.overflow, bus.zero, bus.negative, EXP_SADD_N); end
        drain16();
        issue16(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, lat);
        n_vec++; if (bus.result !== 16'hFFFE) begin n_err++; $display("FAIL sadd_neg_result: got %h want fffe", bus.result); end
        n_vec++; if ({bus.carry, bus.overflow, bus.zero, bus.negative} !== 4'b1001) begin
            n_err++; $display("FAIL sadd_neg_flags: got %b%b%b%b want 1001", bus.carry, bus.overflow, bus.zero, bus.negative); end
        drain16();
    endtask

    task automatic test_back_to_back();
        int lat;
        int stable_bad = 0;
        issue16(1'b0, 1'b0, 16'h1111, 16'h2222, lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op_sub = 1'b0; bus.op_signed = 1'b0; bus.a = 16'h00FF; bus.b = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.result !== 16'h3333 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.carry, bus.overflow, bus.zero, bus.negative} !== 4'b0000) stable_bad++;
        end
        n_vec++; if (stable_bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles want 0", stable_bad); end
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release: got ir=%b ov=%b want 1 0", bus.in_ready, bus.out_valid); end
        @(posedge clk); #1; bus.in_valid = 1'b0;
        bus.a = 16'hAAAA; bus.b = 16'h5555;
        lat = 0;
        while (!bus.out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL bp_new_latency: got %0d want 4", lat); end
        n_vec++; if (bus.result !== 16'h0100) begin n_err++; $display("FAIL bp_new_result: got %h want 0100", bus.result); end
        drain16();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op_sub = 1'b0; bus.op_signed = 1'b0; bus.a = 16'h1234; bus.b = 16'h4321;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.result !== 16'h0000 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid: got ov=%b res=%h ir=%b want 0 0000 1", bus.out_valid, bus.result, bus.in_ready); end
        @(negedge clk); n_rst = 1'b1;
        issue16(1'b0, 1'b0, 16'hFFFF, 16'h0001, lat);
        n_vec++; if (bus.result !== EXP_UADD_OV) begin n_err++; $display("FAIL rst_after_result: got %h want %h", bus.result, EXP_UADD_OV); end
        n_vec++; if ({bus.carry, bus.overflow, bus.zero, bus.negative} !== {1'b1, 1'b1, EXP_UADD_Z, 1'b0}) begin
            n_err++; $display("FAIL rst_after_flags: got %b%b%b%b want 11%b0", bus.carry, bus.overflow, bus.zero, bus.negative, EXP_UADD_Z); end
        drain16();
    endtask

    task automatic test_sweep_c16();
        int lat;
        @(negedge clk);
        bus_c16.in_valid = 1'b1; bus_c16.op_sub = 1'b0; bus_c16.op_signed = 1'b0;
        bus_c16.a = 16'h1234; bus_c16.b = 16'h0001;
        @(posedge clk); #1; bus_c16.in_valid = 1'b0;
        lat = 0;
        while (!bus_c16.out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL c16_latency: got %0d want 1", lat); end
        n_vec++; if (bus_c16.result !== 16'h1235) begin n_err++; $display("FAIL c16_result: got %h want 1235", bus_c16.result); end
        @(negedge clk); bus_c16.out_ready = 1'b1; @(posedge clk); #1; bus_c16.out_ready = 1'b0;
    endtask

    task automatic test_sweep_c1();
        int lat;
        @(negedge clk);
        bus_c1.in_valid = 1'b1; bus_c1.op_sub = 1'b0; bus_c1.op_signed = 1'b0;
        bus_c1.a = 16'h00FF; bus_c1.b = 16'h0F01;
        @(posedge clk); #1; bus_c1.in_valid = 1'b0;
        lat = 0;
        while (!bus_c1.out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat !== 16) begin n_err++; $display("FAIL c1_latency: got %0d want 16", lat); end
        n_vec++; if (bus_c1.result !== 16'h1000) begin n_err++; $display("FAIL c1_result: got %h want 1000", bus_c1.result); end
        @(negedge clk); bus_c1.out_ready = 1'b1; @(posedge clk); #1; bus_c1.out_ready = 1'b0;
    endtask

    task automatic test_sweep_w32();
        int lat;
        @(negedge clk);
        bus_w32.in_valid = 1'b1; bus_w32.op_sub = 1'b1; bus_w32.op_signed = 1'b1;
        bus_w32.a = 32'h8000_0000; bus_w32.b = 32'h0000_0001;
        @(posedge clk); #1; bus_w32.in_valid = 1'b0;
        lat = 0;
        while (!bus_w32.out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL w32_latency: got %0d want 4", lat); end
        n_vec++; if (bus_w32.result !== EXP_W32) begin n_err++; $display("FAIL w32_result: got %h want %h", bus_w32.result, EXP_W32); end
        n_vec++; if ({bus_w32.carry, bus_w32.overflow} !== 2'b11) begin
            n_err++; $display("FAIL w32_flags: got c=%b ov=%b want 1 1", bus_w32.carry, bus_w32.overflow); end
        @(negedge clk); bus_w32.out_ready = 1'b1; @(posedge clk); #1; bus_w32.out_ready = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        bus.in_valid = 1'b0; bus.op_sub = 1'b0; bus.op_signed = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        bus_c16.in_valid = 1'b0; bus_c16.op_sub = 1'b0; bus_c16.op_signed = 1'b0; bus_c16.a = '0; bus_c16.b = '0; bus_c16.out_ready = 1'b0;
        bus_c1.in_valid = 1'b0; bus_c1.op_sub = 1'b0; bus_c1.op_signed = 1'b0; bus_c1.a = '0; bus_c1.b = '0; bus_c1.out_ready = 1'b0;
        bus_w32.in_valid = 1'b0; bus_w32.op_sub = 1'b0; bus_w32.op_signed = 1'b0; bus_w32.a = '0; bus_w32.b = '0; bus_w32.out_ready = 1'b0;
        test_reset();
        test_unsigned_sub();
        test_signed_add();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep_c16();
        test_sweep_c1();
        test_sweep_w32();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/addsub_seq_unit.md
Name: addsub_seq_unit

Overview:
- Parametrised sequential add/subtract unit; successor to the fixed 16-bit registered subtractor.
- Generalised in width, with run-time add/sub and signed/unsigned mode.
- Carry propagates CHUNK_W bits per cycle to keep wide operands off the critical path.
- Sits between operand-issue logic and the result collector. Uses valid/ready on both sides and reports carry, overflow, zero and negative flags.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK_W, 4, bits added per cycle. WIDTH must be a multiple of CHUNK_W; elaboration error otherwise.
- NUM_CHUNKS (localparam), WIDTH/CHUNK_W, number of compute cycles.

Ports:
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept operands
- op_sub  in  1  1 = a-b, 0 = a+b
- op_signed  in  1  1 = two's-complement flag semantics
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference
- carry  out  1  final carry-out (for sub: 1 = no borrow)
- overflow  out  1  range error per mode
- zero  out  1  result == 0
- negative  out  1  result MSB when op_signed, else 0

Behaviour:
- Reset (n_rst low, async): state IDLE, out_valid=0, result=0, all flags 0, internal operand/counter registers 0.
  - in_ready is decoded from state, so it is 1 during and after reset.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch a and b_eff = op_sub ? ~b : b
    - carry-in = op_sub; latch op_sub and op_signed
    - chunk counter = 0; go to BUSY
  - BUSY: in_ready=0. Each cycle:
    - chunk k = a[k] + b_eff[k] + carry is written into result chunk k
    - carry register updated; counter++
    - when k == NUM_CHUNKS-1, flags are registered and the FSM moves to DONE
  - DONE: out_valid=1, in_ready=0. result and flags are held stable until out_valid&&out_ready, then the FSM returns to IDLE (out_valid=0 next cycle).
- Latency:
  - Accept at edge T gives out_valid high after edge T+NUM_CHUNKS.
  - No overlap of operations; throughput is one per NUM_CHUNKS+2 cycles minimum.
- Flags, registered on entry to DONE:
  - carry = final carry-out.
  - overflow, unsigned add = carry.
  - overflow, unsigned sub = ~carry (borrow).
  - overflow, signed = (a[MSB]==b_eff[MSB]) && (result[MSB]!=a[MSB]).
  - zero = (result==0).
  - negative = op_signed & result[MSB].
- Operand inputs are ignored outside the IDLE accept cycle; changes to a/b/op during BUSY have no effect.
- in_valid in DONE/BUSY is not accepted; the upstream holds it.
- Reset mid-operation: immediate abort, partial result discarded, outputs return to reset values.
- During BUSY, result shows partially written chunks; consumers must qualify it with out_valid.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: on overflow, result is clamped before DONE.
  - unsigned add: all ones
  - unsigned sub: 0
  - signed positive overflow: 0 followed by ones
  - signed negative overflow: 1 followed by zeros
  - overflow and carry still report the raw condition; zero and negative reflect the clamped result.
  - Adds no cycles.
- Undefined: result wraps modulo 2^WIDTH; no clamp logic is present.

Decomposition:
- Package addsub_pkg holds:
  - the FSM state enum typedef (IDLE/BUSY/DONE)
  - op encoding constants (OP_ADD=0, OP_SUB=1)
  - a constant function for NUM_CHUNKS
- One sub-module: addsub_chunk, a combinational CHUNK_W-bit adder with carry-in/carry-out, instantiated once and reused across cycles.

Test Plan (WIDTH=16, CHUNK_W=4 unless stated):
- Unsigned sub, a=0x1234, b=0x0234 -> result=0x1000, carry=1, overflow=0, zero=0; out_valid exactly 4 cycles after accept edge.
- Unsigned sub, 0x0001-0x0002 -> result=0xFFFF, carry=0, overflow=1. With ADDSUB_SAT_EN -> result=0x0000, zero=1, overflow=1.
- Signed add, 0x7FFF+0x0001 -> result=0x8000, overflow=1, negative=1. With ADDSUB_SAT_EN -> 0x7FFF, negative=0. Signed 0xFFFF+0xFFFF -> 0xFFFE, overflow=0, negative=1.
- Backpressure: out_ready held low 5 cycles in DONE while in_valid=1 with new operands:
  - result and flags stay stable; in_ready stays 0
  - after handshake, in_ready=1 next cycle and the new operands are accepted then
- Reset mid-op: drive n_rst low during the 2nd BUSY cycle:
  - out_valid=0 and result=0 immediately
  - after release, unsigned 0xFFFF+0x0001 -> 0x0000, carry=1, overflow=1, zero=1
- Parameter sweep: CHUNK_W=16 -> latency 1; CHUNK_W=1 -> latency 16; WIDTH=32, CHUNK_W=8, 0x80000000-0x00000001 signed -> 0x7FFFFFFF, overflow=1.
